// File: rtl/regfile_pkg.sv
// Shared sizing and FSM encoding for the register-file scan controller.
package regfile_pkg;
    localparam int DATA_W = 4;
    localparam int ADDR_W = 2;
    localparam int NREG   = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;
endpackage

// File: rtl/regfile_scan_ctrl_if.sv
// User-side, regfile-side and display signals of the scan controller.
interface regfile_scan_ctrl_if;
    import regfile_pkg::*;

    logic              wr_req;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ack;
    logic              clr_req;
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              rd_ack;
    logic              busy;
    logic              rf_we;
    logic [ADDR_W-1:0] rf_waddr;
    logic [DATA_W-1:0] rf_wdata;
    logic [ADDR_W-1:0] rf_raddr;
    logic [DATA_W-1:0] rf_rdata;
    logic [NREG-1:0]   sel;
    logic [DATA_W-1:0] disp_data;

    modport master (
        output wr_req, wr_addr, wr_data, clr_req, rd_req, rd_addr, rf_rdata,
        input  wr_ack, rd_data, rd_ack, busy, rf_we, rf_waddr, rf_wdata,
               rf_raddr, sel, disp_data
    );

    modport slave (
        input  wr_req, wr_addr, wr_data, clr_req, rd_req, rd_addr, rf_rdata,
        output wr_ack, rd_data, rd_ack, busy, rf_we, rf_waddr, rf_wdata,
               rf_raddr, sel, disp_data
    );
endinterface

// File: rtl/regfile_scan_ctrl_scan_timer.sv
// Digit-slot prescaler, digit index and active-low one-hot select ring.
module scan_timer
    import regfile_pkg::*;
#(
    parameter int SCAN_DIV = 50000
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] digit,
    output logic [NREG-1:0]   sel
);
    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [PW-1:0] presc;
    logic          slot_end;

    assign slot_end = (presc == PW'(SCAN_DIV - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc <= '0;
            digit <= '0;
            sel   <= ~NREG'(1);
        end else if (slot_end) begin
            presc <= '0;
            digit <= (digit == ADDR_W'(NREG - 1)) ? '0 : digit + 1'b1;
            // Rotating the zero left keeps sel aligned with digit.
            sel   <= {sel[NREG-2:0], sel[NREG-1]};
        end else begin
            presc <= presc + 1'b1;
        end
    end
endmodule

// File: rtl/regfile_scan_ctrl.sv
// Owns the regfile ports: user writes, clear-all sweep, and a read port
// shared between user reads (priority) and the display scan.
module regfile_scan_ctrl
    import regfile_pkg::*;
#(
    parameter int SCAN_DIV = 50000
) (
    input  logic                clk,
    input  logic                rst,
    regfile_scan_ctrl_if.slave  bus
);
    state_t            state;
    logic [ADDR_W-1:0] clr_idx;
    logic              pend_vld;
    logic [ADDR_W-1:0] pend_addr;
    logic [ADDR_W-1:0] digit;
    logic              user_rd;
    logic [ADDR_W-1:0] user_addr;

    scan_timer #(.SCAN_DIV(SCAN_DIV)) u_scan (
        .clk   (clk),
        .rst   (rst),
        .digit (digit),
        .sel   (bus.sel)
    );

    assign user_rd   = (bus.rd_req || pend_vld) && (state == IDLE);
    assign user_addr = bus.rd_req ? bus.rd_addr : pend_addr;
    assign bus.busy  = (state == CLEAR);

    always_comb begin
        bus.rf_we    = 1'b0;
        bus.rf_waddr = bus.wr_addr;
        bus.rf_wdata = bus.wr_data;
        bus.wr_ack   = 1'b0;
        if (state == CLEAR) begin
            bus.rf_we    = !rst;
            bus.rf_waddr = clr_idx;
            bus.rf_wdata = '0;
        end else begin
            bus.rf_we    = bus.wr_req && !rst;
            bus.wr_ack   = bus.wr_req;
        end
        bus.rf_raddr = user_rd ? user_addr : digit;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            clr_idx       <= '0;
            pend_vld      <= 1'b0;
            pend_addr     <= '0;
            bus.rd_data   <= '0;
            bus.rd_ack    <= 1'b0;
            bus.disp_data <= '0;
        end else begin
            case (state)
                IDLE: if (bus.clr_req) begin
                    state   <= CLEAR;
                    clr_idx <= '0;
                end
                CLEAR: begin
                    if (clr_idx == ADDR_W'(NREG - 1)) state <= IDLE;
                    clr_idx <= clr_idx + 1'b1;
                end
                default: state <= IDLE;
            endcase

            bus.rd_ack <= user_rd;
            if (user_rd) begin
                bus.rd_data <= bus.rf_rdata;
                pend_vld    <= 1'b0;
            end else begin
                bus.disp_data <= bus.rf_rdata;
                // Reads arriving mid-clear wait here; the newest address wins.
                if (bus.rd_req) begin
                    pend_vld  <= 1'b1;
                    pend_addr <= bus.rd_addr;
                end
            end
        end
    end
endmodule
